// File: rtl/polyshift_seq.sv
// polyshift_seq: multi-cycle logarithmic shifter with a valid/ready handshake.
// Supports logical, arithmetic, double-precision (fill from c_i) and cyclic shifts
// in either direction. Stages resolve STAGES_PER_CYCLE per BUSY cycle.
// Optional build macro POLYSHIFT_SEQ_ZERO_BYPASS_EN: zero-amount requests skip BUSY.
//
// Datapath note: the operand lives in a 2*WORD_WIDTH extended word holding the
// data, the fill bits and one carry slot, so every shift type reduces to a plain
// left or right shift of that word and stages compose naturally.
//   left : {carry, data, fill}  -> result = top window, carry = MSB
//   right: {fill, data, carry}  -> result = bits [W:1],  carry = LSB
module polyshift_seq #(
  parameter int unsigned WORD_WIDTH       = 32,
  parameter int unsigned STAGES_PER_CYCLE = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          valid_i,
  output logic                          ready_o,
  input  logic [WORD_WIDTH-1:0]         data_i,
  input  logic [WORD_WIDTH-2:0]         c_i,
  input  logic [$clog2(WORD_WIDTH)-1:0] shift_size_i,
  input  logic [1:0]                    shift_type_i,
  input  logic                          dir_i,
  output logic                          valid_o,
  input  logic                          ready_i,
  output logic [WORD_WIDTH-1:0]         data_o,
  output logic                          carry_o
);

  localparam int unsigned Log       = $clog2(WORD_WIDTH);
  localparam int unsigned NumCycles = (Log + STAGES_PER_CYCLE - 1) / STAGES_PER_CYCLE;
  localparam int unsigned CntW      = (NumCycles > 1) ? $clog2(NumCycles) : 1;
  localparam int unsigned ExtW      = 2 * WORD_WIDTH;

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                state_q, state_d;
  logic [ExtW-1:0]       ext_q, ext_load, ext_step;
  logic [WORD_WIDTH-2:0] fill;
  logic [Log-1:0]        amt_q, amt_bits;
  logic                  dir_q;
  logic [CntW-1:0]       cnt_q;
  logic                  accept, last_busy, bypass;
  int unsigned           stage;

  assign accept    = (state_q == StIdle) && valid_i;
  assign last_busy = (cnt_q == CntW'(NumCycles - 1));

`ifdef POLYSHIFT_SEQ_ZERO_BYPASS_EN
  assign bypass = (shift_size_i == '0);
`else
  assign bypass = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= StIdle;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (valid_i) state_d = bypass ? StDone : StBusy;
      StBusy:  if (last_busy) state_d = StDone;
      StDone:  if (ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake and result outputs
  always_comb begin
    ready_o = (state_q == StIdle);
    valid_o = (state_q == StDone);
    data_o  = dir_q ? ext_q[WORD_WIDTH:1] : ext_q[ExtW-2:WORD_WIDTH-1];
    carry_o = dir_q ? ext_q[0] : ext_q[ExtW-1];
  end

  // Build the extended word from the request: fill bits depend on type and direction
  always_comb begin
    fill = '0;
    case (shift_type_i)
      2'd1:    if (dir_i) fill = {(WORD_WIDTH-1){data_i[WORD_WIDTH-1]}};
      2'd2:    fill = c_i;
      2'd3:    fill = dir_i ? data_i[WORD_WIDTH-2:0] : data_i[WORD_WIDTH-1:1];
      default: fill = '0;
    endcase
    ext_load = dir_i ? {fill, data_i, 1'b0} : {1'b0, data_i, fill};
  end

  // Resolve this cycle's group of log stages (stage k shifts by 2^k when n[k] is set)
  always_comb begin
    ext_step = ext_q;
    stage    = 0;
    amt_bits = '0;
    for (int unsigned s = 0; s < STAGES_PER_CYCLE; s++) begin
      stage    = 32'(cnt_q) * STAGES_PER_CYCLE + s;
      amt_bits = amt_q >> stage;
      if ((stage < Log) && amt_bits[0]) begin
        ext_step = dir_q ? (ext_step >> (32'd1 << stage)) : (ext_step << (32'd1 << stage));
      end
    end
  end

  // Operand capture on acceptance, stage progression while busy
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      ext_q <= '0;
      amt_q <= '0;
      dir_q <= 1'b0;
      cnt_q <= '0;
    end else if (accept) begin
      ext_q <= ext_load;
      amt_q <= shift_size_i;
      dir_q <= dir_i;
      cnt_q <= '0;
    end else if (state_q == StBusy) begin
      ext_q <= ext_step;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_polyshift_seq.sv
// Testbench for polyshift_seq (WORD_WIDTH=8, STAGES_PER_CYCLE=1): directed vector
// table, handshake/reset sequences and randomized operations against an
// arithmetic reference model.
module tb_polyshift_seq;

  localparam int BusyLat = 3;
`ifdef POLYSHIFT_SEQ_ZERO_BYPASS_EN
  localparam int ZeroLat = 0;
`else
  localparam int ZeroLat = 3;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_i = 1'b0;
  logic       dir_i = 1'b0;
  logic [7:0] data_i = '0;
  logic [6:0] c_i = '0;
  logic [2:0] n_i = '0;
  logic [1:0] type_i = '0;
  logic       ready_o, valid_o, carry_o;
  logic [7:0] data_o;

  int n_checks = 0;
  int n_fail = 0;

  polyshift_seq #(
    .WORD_WIDTH      (8),
    .STAGES_PER_CYCLE(1)
  ) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .data_i      (data_i),
    .c_i         (c_i),
    .shift_size_i(n_i),
    .shift_type_i(type_i),
    .dir_i       (dir_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .data_o      (data_o),
    .carry_o     (carry_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic [6:0] c;
    logic [2:0] n;
    logic [1:0] t;
    logic       dr;
    logic [7:0] ed;
    logic       ec;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: result and carry from the shift definitions, plain integer arithmetic
  function automatic logic [8:0] model(input logic [7:0] d, input logic [6:0] c,
                                       input logic [2:0] n, input logic [1:0] t,
                                       input logic dr);
    int unsigned dd, cc, nn, r, cy;
    dd = 32'(d);
    cc = 32'(c);
    nn = 32'(n);
    if (nn == 0) begin
      r  = dd;
      cy = 0;
    end else if (!dr) begin
      case (t)
        2'd2:    r = (dd << nn) | (cc >> (7 - nn));
        2'd3:    r = (dd << nn) | (dd >> (8 - nn));
        default: r = dd << nn;
      endcase
      cy = (dd >> (8 - nn)) & 1;
    end else begin
      case (t)
        2'd1:    r = (dd >> nn) | (d[7] ? (32'hFF << (8 - nn)) : 0);
        2'd2:    r = ((cc & ((32'd1 << nn) - 1)) << (8 - nn)) | (dd >> nn);
        2'd3:    r = (dd >> nn) | (dd << (8 - nn));
        default: r = dd >> nn;
      endcase
      cy = (dd >> (nn - 1)) & 1;
    end
    r = r & 32'hFF;
    return {cy[0], r[7:0]};
  endfunction

  // Launch one request and wait (bounded) for valid_o; lat counts edges after acceptance
  task automatic run_op(input logic [7:0] d, input logic [6:0] c, input logic [2:0] n,
                        input logic [1:0] t, input logic dr, input logic early_ready,
                        output logic [7:0] res, output logic cy, output int lat);
    int guard;
    guard = 0;
    while (!ready_o && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    @(negedge clk);
    data_i  = d;
    c_i     = c;
    n_i     = n;
    type_i  = t;
    dir_i   = dr;
    valid_i = 1'b1;
    ready_i = early_ready;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    lat = 0;
    while (!valid_o && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = data_o;
    cy  = carry_o;
  endtask

  task automatic consume();
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    ready_i = 1'b0;
    check("release_valid", 32'(valid_o), 32'd0);
    check("release_ready", 32'(ready_o), 32'd1);
  endtask

  initial begin
    logic [7:0] res;
    logic       cy;
    logic [8:0] m;
    int         lat;
    logic       seen;
    logic [7:0] rd;
    logic [6:0] rc;
    logic [2:0] rn;
    logic [1:0] rt;
    logic       rdir, early;

    //          d      c      n     t     dr    ed     ec
    vecs[0] = '{8'h81, 7'h00, 3'd1, 2'd0, 1'b0, 8'h02, 1'b1};
    vecs[1] = '{8'h90, 7'h00, 3'd3, 2'd1, 1'b1, 8'hF2, 1'b0};
    vecs[2] = '{8'h90, 7'h00, 3'd3, 2'd0, 1'b1, 8'h12, 1'b0};
    vecs[3] = '{8'h0F, 7'h7F, 3'd4, 2'd2, 1'b0, 8'hFF, 1'b0};
    vecs[4] = '{8'hF0, 7'h05, 3'd4, 2'd2, 1'b1, 8'h5F, 1'b0};
    vecs[5] = '{8'h01, 7'h00, 3'd7, 2'd3, 1'b1, 8'h02, 1'b0};
    vecs[6] = '{8'hA5, 7'h00, 3'd0, 2'd0, 1'b0, 8'hA5, 1'b0};
    vecs[7] = '{8'hA5, 7'h33, 3'd0, 2'd1, 1'b1, 8'hA5, 1'b0};
    vecs[8] = '{8'h81, 7'h00, 3'd1, 2'd3, 1'b0, 8'h03, 1'b1};
    vecs[9] = '{8'h80, 7'h00, 3'd7, 2'd1, 1'b1, 8'hFF, 1'b0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_data", 32'(data_o), 32'd0);
    check("rst_carry", 32'(carry_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vector table
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].d, vecs[i].c, vecs[i].n, vecs[i].t, vecs[i].dr, 1'b0, res, cy, lat);
      check($sformatf("vec%0d_data", i), 32'(res), 32'(vecs[i].ed));
      check($sformatf("vec%0d_carry", i), 32'(cy), 32'(vecs[i].ec));
      check($sformatf("vec%0d_latency", i), 32'(lat),
            32'((vecs[i].n == 3'd0) ? ZeroLat : BusyLat));
      consume();
    end

    // Hold result while consumer stalls; requests during DONE are ignored
    run_op(8'h01, 7'h00, 3'd7, 2'd3, 1'b1, 1'b0, res, cy, lat);
    check("hold_first", 32'(res), 32'h02);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      valid_i = 1'b1;
      data_i  = 8'hFF;
      n_i     = 3'd1;
      @(posedge clk);
      #1;
      check("hold_data", 32'(data_o), 32'h02);
      check("hold_valid", 32'(valid_o), 32'd1);
      check("hold_ready", 32'(ready_o), 32'd0);
    end
    @(negedge clk);
    valid_i = 1'b0;
    consume();
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (valid_o) seen = 1'b1;
    end
    check("hold_not_queued", 32'(seen), 32'd0);

    // Reset in second BUSY cycle, with a simultaneous valid_i: operation discarded
    @(negedge clk);
    data_i  = 8'h81;
    n_i     = 3'd1;
    type_i  = 2'd0;
    dir_i   = 1'b0;
    valid_i = 1'b1;
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    check("busy_ready", 32'(ready_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b0;
    valid_i = 1'b1;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_data", 32'(data_o), 32'd0);
    check("midrst_carry", 32'(carry_o), 32'd0);
    @(negedge clk);
    valid_i = 1'b0;
    ready_i = 1'b0;
    rst_n   = 1'b1;
    seen    = 1'b0;
    repeat (8) begin
      @(posedge clk);
      #1;
      if (valid_o) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);

    // Randomized operations against the reference model
    for (int i = 0; i < 150; i++) begin
      rd    = 8'($urandom_range(0, 255));
      rc    = 7'($urandom_range(0, 127));
      rn    = 3'($urandom_range(0, 7));
      rt    = 2'($urandom_range(0, 3));
      rdir  = 1'($urandom_range(0, 1));
      early = ($urandom_range(0, 3) == 0);
      m = model(rd, rc, rn, rt, rdir);
      run_op(rd, rc, rn, rt, rdir, early, res, cy, lat);
      check($sformatf("rnd%0d_data d=%0h c=%0h n=%0d t=%0d r=%0d", i, rd, rc, rn, rt, rdir),
            32'(res), 32'(m[7:0]));
      check($sformatf("rnd%0d_carry", i), 32'(cy), 32'(m[8]));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'((rn == 3'd0) ? ZeroLat : BusyLat));
      if (!early) repeat ($urandom_range(0, 3)) @(posedge clk);
      consume();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
